ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 8-bit RAM between two requesters:
  - the microprocessor's memory path (MAR/MBR), called the CPU port;
  - a loader/DMA port, used for program load and I/O buffers.
- Makes a registered per-cycle grant decision using fixed-priority or round-robin arbitration, with a starvation limit.
- Drives the RAM address, data and write-enable from the granted port, and returns read data with a valid strobe.
- Sits between the processor top level and the RAM.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RR_MODE, 0: 0 = fixed CPU priority; 1 = round-robin on contention.
- MAX_RUN, 4: maximum consecutive grants to one port while the other port is requesting, range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access is being performed this cycle.
- cpu_rvalid  out  1  ram_rdata holds the CPU read result.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same meaning for the DMA port.
- dma_gnt, dma_rvalid  out  1/1  same meaning for the DMA port.
- ram_out  in  DATA_W  RAM read data, valid the cycle after the address is applied.
- ram_rdata  out  DATA_W  ram_out passed through to both ports.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.

Behaviour:
- Reset: state IDLE; cpu_gnt = dma_gnt = 0; cpu_rvalid = dma_rvalid = 0; run_cnt = 0; last_owner = DMA, so CPU wins the first round-robin tie.
  - ram_we = 0 whenever the state is IDLE.
  - Reset asserted mid-access takes effect at the next edge. Any pending rvalid is squashed; no write is issued in the cycle after reset.
- States: IDLE, SERV_CPU, SERV_DMA. The state encodes the owner of the current cycle.
- Decision at each edge, from the requests sampled at that edge:
  - No request -> IDLE.
  - One request -> that port.
  - Both requesting:
    - If last_owner has run_cnt == MAX_RUN, the other port wins.
    - Else if RR_MODE = 1, the port other than last_owner wins.
    - Else the CPU wins.
- Counter and owner update on each grant:
  - run_cnt increments if the new owner equals last_owner and the other port was requesting.
  - Otherwise run_cnt resets to 1.
  - run_cnt saturates at MAX_RUN.
  - last_owner is updated on every grant. IDLE leaves last_owner unchanged and clears run_cnt.
- Grant latency:
  - A request that is high at edge t, and that wins, gives gnt = 1 for cycle t+1.
  - Minimum latency is one cycle.
  - gnt is a registered output and is one-hot or zero.
- During a granted cycle:
  - ram_addr, ram_data and ram_we are taken combinationally from the owner's inputs.
  - The write commits at the end of that cycle.
- Outputs when IDLE: ram_addr = 0, ram_data = 0, ram_we = 0.
- Requester protocol:
  - A requester holds req, addr, we and wdata stable until it sees gnt = 1.
  - Keeping req high through the grant edge counts as a new request, which allows back-to-back accesses (one per cycle).
  - Dropping req before the grant is legal; the request is simply lost.
- Read return: a granted read in cycle t+1 gives that port's rvalid = 1 in cycle t+2, with ram_rdata = ram_out. rvalid is registered and lasts one cycle.
- Write response: a granted write produces no rvalid.
- Fairness bound: under continuous contention, the losing port waits at most MAX_RUN cycles.
- Owner switch: on a switch between ports, the previous owner's rvalid may coincide with the new owner's gnt. This is legal and must not be corrupted.

Test Plan:
1. Reset, then CPU read of address 0x10 with RAM[0x10] = 0x5A:
   - cpu_req at edge 1 -> cpu_gnt in cycle 2 with ram_addr = 0x10, ram_we = 0;
   - cpu_rvalid = 1 in cycle 3 with ram_rdata = 0x5A;
   - dma_gnt stays 0 throughout.
2. DMA writes 0xA3 to 0x20, then 0x3C to 0x21, back-to-back:
   - dma_gnt high for two consecutive cycles;
   - ram_we = 1 in both, with the correct address and data;
   - a CPU read of 0x21 afterwards returns 0x3C.
3. RR_MODE = 0, MAX_RUN = 4, both ports requesting continuously:
   - grant pattern after reset is C,C,C,C,D,C,C,C,C,D;
   - no two gnts are high in the same cycle.
4. RR_MODE = 1, both ports requesting continuously -> grant pattern C,D,C,D,…
5. Reset asserted in the cycle a CPU read is granted:
   - the next cycle has cpu_gnt = 0, cpu_rvalid = 0, ram_we = 0;
   - state is IDLE and the first subsequent round-robin tie goes to the CPU.
6. No requests for 10 cycles -> ram_we = 0, both gnts = 0, ram_addr = 0, and run_cnt is cleared.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the CPU memory path and a
// loader/DMA port. The owner of each cycle is chosen at the preceding edge
// (fixed CPU priority or round-robin on contention) with a starvation limit.
// The owner's address, data and write enable drive the RAM combinationally
// during its granted cycle. Reads return one cycle later with a valid strobe.
module ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 0,
  parameter int MAX_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERV_CPU = 2'd1,
    SERV_DMA = 2'd2
  } state_t;

  // last_owner encoding: 0 = CPU, 1 = DMA
  localparam logic       OWNER_CPU = 1'b0;
  localparam logic       OWNER_DMA = 1'b1;
  localparam logic [3:0] MAX_RUN_C = 4'(MAX_RUN);

  state_t              state_r;
  state_t              state_next_s;
  logic                last_owner_r;
  logic                last_owner_next_s;
  logic [3:0]          run_cnt_r;
  logic [3:0]          run_cnt_next_s;
  logic                cont_s;
  logic                win_dma_s;
  logic                new_owner_s;
  logic                cpu_gnt_r;
  logic                dma_gnt_r;
  logic                cpu_rvalid_r;
  logic                dma_rvalid_r;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_data_s;
  logic                ram_we_s;

  // Next owner, run counter and last owner from the requests seen this edge
  always_comb begin
    state_next_s      = IDLE;
    last_owner_next_s = last_owner_r;
    run_cnt_next_s    = run_cnt_r;
    cont_s            = cpu_req & dma_req;
    win_dma_s         = 1'b0;
    new_owner_s       = OWNER_CPU;

    // Contention: the starvation limit beats the mode; round-robin alternates
    if (cont_s) begin
      if (run_cnt_r == MAX_RUN_C) begin
        win_dma_s = (last_owner_r == OWNER_CPU);
      end else if (RR_MODE != 0) begin
        win_dma_s = (last_owner_r == OWNER_CPU);
      end else begin
        win_dma_s = 1'b0;
      end
    end else begin
      win_dma_s = 1'b0;
    end

    case ({cpu_req, dma_req})
      2'b00:   state_next_s = IDLE;
      2'b10:   state_next_s = SERV_CPU;
      2'b01:   state_next_s = SERV_DMA;
      2'b11:   state_next_s = win_dma_s ? SERV_DMA : SERV_CPU;
      default: state_next_s = IDLE;
    endcase

    // A run only grows while the other port was kept waiting
    if (state_next_s == IDLE) begin
      run_cnt_next_s = 4'd0;
    end else begin
      new_owner_s       = (state_next_s == SERV_DMA) ? OWNER_DMA : OWNER_CPU;
      last_owner_next_s = new_owner_s;
      if ((new_owner_s == last_owner_r) && cont_s) begin
        if (run_cnt_r >= MAX_RUN_C) begin
          run_cnt_next_s = MAX_RUN_C;
        end else begin
          run_cnt_next_s = run_cnt_r + 4'd1;
        end
      end else begin
        run_cnt_next_s = 4'd1;
      end
    end
  end

  // State, grant and read-valid registers; reset squashes any pending rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_owner_r <= OWNER_DMA;
      run_cnt_r    <= 4'd0;
      cpu_gnt_r    <= 1'b0;
      dma_gnt_r    <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      dma_rvalid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      last_owner_r <= last_owner_next_s;
      run_cnt_r    <= run_cnt_next_s;
      cpu_gnt_r    <= (state_next_s == SERV_CPU);
      dma_gnt_r    <= (state_next_s == SERV_DMA);
      cpu_rvalid_r <= (state_r == SERV_CPU) && !cpu_we;
      dma_rvalid_r <= (state_r == SERV_DMA) && !dma_we;
    end
  end

  // RAM side follows the current owner's inputs; idle drives all zeros
  always_comb begin
    ram_addr_s = '0;
    ram_data_s = '0;
    ram_we_s   = 1'b0;
    case (state_r)
      SERV_CPU: begin
        ram_addr_s = cpu_addr;
        ram_data_s = cpu_wdata;
        ram_we_s   = cpu_we;
      end
      SERV_DMA: begin
        ram_addr_s = dma_addr;
        ram_data_s = dma_wdata;
        ram_we_s   = dma_we;
      end
      default: begin
        ram_addr_s = '0;
        ram_data_s = '0;
        ram_we_s   = 1'b0;
      end
    endcase
  end

  assign cpu_gnt    = cpu_gnt_r;
  assign dma_gnt    = dma_gnt_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign dma_rvalid = dma_rvalid_r;
  assign ram_rdata  = ram_out;
  assign ram_addr   = ram_addr_s;
  assign ram_data   = ram_data_s;
  assign ram_we     = ram_we_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a fixed-priority and a round-robin instance receive
// identical stimulus, each with its own RAM, and are compared against a
// history-based model of ownership, fairness and the RAM contents.
module tb_ram_arbiter;

  localparam int MAXR = 4;

  logic       clk = 1'b0;
  logic       rst, load;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [1:0] cpu_gnt_v, dma_gnt_v, cpu_rvalid_v, dma_rvalid_v, ram_we_v;
  logic [7:0] ram_rdata_v [2];
  logic [7:0] ram_addr_v  [2];
  logic [7:0] ram_data_v  [2];
  logic [7:0] ram_out_v   [2];
  logic [7:0] mem    [2][256];
  logic [7:0] refmem [2][256];

  // model state
  int         g_cur  [2];   // 0 idle, 1 CPU, 2 DMA for the current cycle
  int         lastown[2];
  int         hlen   [2];
  int         h_own  [2][16];
  bit         h_oth  [2][16];
  bit         pend_c [2];
  bit         pend_d [2];
  logic [7:0] pend_data[2];
  string      pat    [2];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_MODE(0), .MAX_RUN(MAXR)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_v[0]), .cpu_rvalid(cpu_rvalid_v[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_v[0]), .dma_rvalid(dma_rvalid_v[0]),
    .ram_out(ram_out_v[0]), .ram_rdata(ram_rdata_v[0]), .ram_addr(ram_addr_v[0]),
    .ram_data(ram_data_v[0]), .ram_we(ram_we_v[0]));

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_MODE(1), .MAX_RUN(MAXR)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_v[1]), .cpu_rvalid(cpu_rvalid_v[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_v[1]), .dma_rvalid(dma_rvalid_v[1]),
    .ram_out(ram_out_v[1]), .ram_rdata(ram_rdata_v[1]), .ram_addr(ram_addr_v[1]),
    .ram_data(ram_data_v[1]), .ram_we(ram_we_v[1]));

  function automatic logic [7:0] seed_val(int i);
    return (i == 16) ? 8'h5A : 8'(i * 13 + 7);
  endfunction

  // RAM models: registered read, write at end of cycle
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (load) begin
        for (int i = 0; i < 256; i++) mem[m][i] <= seed_val(i);
      end else if (ram_we_v[m]) begin
        mem[m][ram_addr_v[m]] <= ram_data_v[m];
      end
      ram_out_v[m] <= mem[m][ram_addr_v[m]];
    end
  end

  task automatic chk(string tag, int m, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, m, obs, exp);
    end
  endtask

  task automatic chk_str(string tag, string obs, string exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  // Length of the current run of the last owner, built from grant history
  function automatic int streak(int m);
    int n, j, o;
    if (hlen[m] == 0) return 0;
    o = h_own[m][hlen[m]-1];
    if (o == 0) return 0;
    n = 1;
    j = hlen[m] - 1;
    while (j > 0 && n < MAXR && h_own[m][j-1] == o && h_oth[m][j]) begin
      n++;
      j--;
    end
    return n;
  endfunction

  function automatic int decide(int m, bit cr, bit dr);
    if (!cr && !dr) return 0;
    if (cr && !dr) return 1;
    if (!cr && dr) return 2;
    if (streak(m) == MAXR) return 3 - lastown[m];
    if (m == 1) return 3 - lastown[m];
    return 1;
  endfunction

  task automatic push(int m, int o, bit oth);
    if (hlen[m] == 16) begin
      for (int i = 0; i < 15; i++) begin
        h_own[m][i] = h_own[m][i+1];
        h_oth[m][i] = h_oth[m][i+1];
      end
      hlen[m] = 15;
    end
    h_own[m][hlen[m]] = o;
    h_oth[m][hlen[m]] = oth;
    hlen[m]++;
    if (o != 0) lastown[m] = o;
  endtask

  task automatic model_reset(int m);
    hlen[m]    = 0;
    lastown[m] = 2;
    pend_c[m]  = 1'b0;
    pend_d[m]  = 1'b0;
  endtask

  // One cycle: drive inputs, check the cycle, advance the model, cross the edge
  task automatic step(input bit r, input bit cr, input bit cw, input logic [7:0] ca,
                      input logic [7:0] cd, input bit dr, input bit dw,
                      input logic [7:0] da, input logic [7:0] dd);
    logic [7:0] ea, ed;
    logic       ew;
    int         gn, g;
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    for (int m = 0; m < 2; m++) begin
      g = g_cur[m];
      if (cpu_gnt_v[m] === 1'b1) pat[m] = {pat[m], "C"};
      else if (dma_gnt_v[m] === 1'b1) pat[m] = {pat[m], "D"};
      else pat[m] = {pat[m], "-"};
      chk("cpu_gnt", m, 32'(cpu_gnt_v[m]), 32'(g == 1));
      chk("dma_gnt", m, 32'(dma_gnt_v[m]), 32'(g == 2));
      ea = 8'h00; ed = 8'h00; ew = 1'b0;
      if (g == 1) begin ea = ca; ed = cd; ew = cw; end
      if (g == 2) begin ea = da; ed = dd; ew = dw; end
      chk("ram_addr", m, 32'(ram_addr_v[m]), 32'(ea));
      chk("ram_data", m, 32'(ram_data_v[m]), 32'(ed));
      chk("ram_we", m, 32'(ram_we_v[m]), 32'(ew));
      chk("cpu_rvalid", m, 32'(cpu_rvalid_v[m]), 32'(pend_c[m]));
      chk("dma_rvalid", m, 32'(dma_rvalid_v[m]), 32'(pend_d[m]));
      if (pend_c[m] || pend_d[m]) chk("ram_rdata", m, 32'(ram_rdata_v[m]), 32'(pend_data[m]));
      pend_c[m] = (g == 1) && !cw;
      pend_d[m] = (g == 2) && !dw;
      if (g == 1) pend_data[m] = refmem[m][ca];
      if (g == 2) pend_data[m] = refmem[m][da];
      if (g == 1 && cw) refmem[m][ca] = cd;
      if (g == 2 && dw) refmem[m][da] = dd;
      if (r) begin
        model_reset(m);
        gn = 0;
      end else begin
        gn = decide(m, cr, dr);
        push(m, gn, (gn == 1) ? dr : ((gn == 2) ? cr : 1'b0));
      end
      g_cur[m] = gn;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; load = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) refmem[m][i] = seed_val(i);
      model_reset(m);
      g_cur[m] = 0;
      pat[m] = "";
    end
    repeat (2) @(posedge clk);
    #1;
    load = 1'b0;

    // CPU read of 0x10 (also checks the reset state in the first step)
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t1_rvalid", 0, 32'(cpu_rvalid_v[0]), 32'd1);
    chk("t1_rdata", 0, 32'(ram_rdata_v[0]), 32'h5A);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    // DMA back-to-back writes, then a CPU read of the second location
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hA3);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hA3);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h21, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t2_rdata", 0, 32'(ram_rdata_v[0]), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset lands on the cycle a CPU read is granted
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int m = 0; m < 2; m++) begin
      chk("t5_gnt", m, 32'(cpu_gnt_v[m]), 32'd0);
      chk("t5_rvalid", m, 32'(cpu_rvalid_v[m]), 32'd0);
      chk("t5_we", m, 32'(ram_we_v[m]), 32'd0);
    end

    // Continuous contention straight after reset
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
    pat[0] = ""; pat[1] = "";
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'(i + 64), 8'h00);
    chk_str("pattern_fixed", pat[0], "CCCCDCCCCD");
    chk_str("pattern_rr", pat[1], "CDCDCDCDCD");

    // Long idle, then contention again from a cleared run count
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int m = 0; m < 2; m++) begin
      chk("t6_addr", m, 32'(ram_addr_v[m]), 32'd0);
      chk("t6_we", m, 32'(ram_we_v[m]), 32'd0);
    end
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b1, 8'(i + 128), 8'(i * 3), 1'b1, 1'b0, 8'(i + 128), 8'h00);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(($urandom % 64) == 0, ($urandom % 4) != 0, $urandom % 2, 8'($urandom % 16),
           8'($urandom), ($urandom % 4) != 0, $urandom % 2, 8'($urandom % 16), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
